// File: rtl/ram_pkg.sv
// ram_pkg: shared CPU word/address sizes and word type for the memory
package ram_pkg;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 16;
   typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/ram.sv
// ram: simple dual-port synchronous RAM, registered read with write-first bypass
//   clk, rst         rising-edge clock, synchronous active-high reset (clears dout only)
//   raddr, waddr     read/write addresses, wrapped modulo DEPTH
//   din, we          write data and write enable (blocked while rst)
//   dout             registered read data, one-cycle latency
module ram
   import ram_pkg::*;
#(
   parameter int DATA_W = ram_pkg::DATA_W,
   parameter int ADDR_W = ram_pkg::ADDR_W,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] raddr,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] din,
   input  logic              we,
   output logic [DATA_W-1:0] dout
);
   localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] dout_d, dout_q;
   logic [IDX_W-1:0]  ra, wa;
   assign ra = raddr[IDX_W-1:0];
   assign wa = waddr[IDX_W-1:0];
   // bypass compares wrapped indices so aliased addresses also forward
   always_comb dout_d = (we && ra == wa) ? din : mem[ra];
   always_ff @(posedge clk)
      if (we && !rst) mem[wa] <= din;
   always_ff @(posedge clk)
      if (rst) dout_q <= '0;
      else dout_q <= dout_d;
   assign dout = dout_q;
endmodule

// File: tb/tb_ram.sv
// tb_ram: directed self-checking bench for ram
module tb_ram;
   import ram_pkg::*;
   logic                clk = 1'b0;
   logic                rst, we;
   logic [ADDR_W-1:0]   raddr, waddr;
   word_t               din, dout;
   int                  n_chk = 0;
   int                  n_fail = 0;
   ram dut (
      .clk   (clk),
      .rst   (rst),
      .raddr (raddr),
      .waddr (waddr),
      .din   (din),
      .we    (we),
      .dout  (dout)
   );
   always #5 clk = ~clk;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input word_t exp);
      n_chk++;
      assert (dout === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, dout, exp);
      end
   endtask
   task automatic wr(input logic [ADDR_W-1:0] a, input word_t d);
      we = 1'b1;
      waddr = a;
      din = d;
      step();
      we = 1'b0;
   endtask
   task automatic rd(input logic [ADDR_W-1:0] a);
      raddr = a;
      step();
   endtask
   initial begin
      rst = 1'b1;
      we = 1'b0;
      raddr = '0;
      waddr = '0;
      din = '0;
      step();
      step();
      chk("reset_dout", 16'h0000);
      rst = 1'b0;
      // pipeline: read trails write by one address
      raddr = 16'd7;
      wr(16'd0, 16'hff00);
      for (int k = 1; k <= 4; k++) begin
         raddr = 16'(k - 1);
         we = 1'b1;
         waddr = 16'(k);
         din = 16'hff00 + 16'(k);
         step();
         chk($sformatf("pipe_rd%0d", k - 1), 16'hff00 + 16'(k - 1));
      end
      we = 1'b0;
      rd(16'd4);
      chk("pipe_rd4", 16'hff04);
      #3;
      chk("hold_between_edges", 16'hff04);
      // reset clears dout but not memory
      wr(16'd5, 16'h1234);
      rd(16'd5);
      chk("pre_reset_rd5", 16'h1234);
      rst = 1'b1;
      step();
      chk("reset_clears_dout", 16'h0000);
      rst = 1'b0;
      step();
      chk("post_reset_rd5", 16'h1234);
      // write-first bypass
      raddr = 16'd0;
      wr(16'd7, 16'haaaa);
      rd(16'd7);
      chk("rd7_old", 16'haaaa);
      wr(16'd7, 16'h5555);
      chk("bypass_rd7", 16'h5555);
      rd(16'd7);
      chk("rd7_new", 16'h5555);
      // write-enable gating
      wr(16'd9, 16'h0f0f);
      we = 1'b0;
      waddr = 16'd9;
      din = 16'hffff;
      raddr = 16'd9;
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("we0_rd9_%0d", k), 16'h0f0f);
      end
      rd(16'd9);
      chk("we0_final_rd9", 16'h0f0f);
      // reset blocks writes
      raddr = 16'd0;
      wr(16'd2, 16'h1111);
      rst = 1'b1;
      raddr = 16'd2;
      wr(16'd2, 16'h2222);
      chk("rst_write_dout", 16'h0000);
      rst = 1'b0;
      rd(16'd2);
      chk("rst_blocks_write", 16'h1111);
      // address extremes and port independence
      raddr = 16'd5;
      wr(16'hffff, 16'hffff);
      wr(16'h0000, 16'h0001);
      rd(16'hffff);
      chk("rd_ffff", 16'hffff);
      raddr = 16'h0000;
      wr(16'h0010, 16'habcd);
      chk("concurrent_rd0", 16'h0001);
      rd(16'h0010);
      chk("rd_0010", 16'habcd);
      rd(16'h0000);
      chk("rd_0000_again", 16'h0001);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
